pix_gray_scan: RTL
==================

PIX_GRAY_SCAN -- requirements
Module: pix_gray_scan

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, meaning row/col address width; image is 2^ADDR_W x 2^ADDR_W pixels.
REQ-002 SHALL have parameter CH_W, default 8, meaning per-channel width; pixel is {R,G,B}, 3*CH_W bits, R in MSBs.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request one full-image pass; sampled only in IDLE.
REQ-006 SHALL have port in_pix  input  3*CH_W  pixel at (row,col), combinational read, valid in the same cycle the address is driven.
REQ-007 SHALL have port row  output  ADDR_W  current pixel row address.
REQ-008 SHALL have port col  output  ADDR_W  current pixel column address.
REQ-009 SHALL have port out_we  output  1  write enable for out_pix at (row,col).
REQ-010 SHALL have port out_pix  output  3*CH_W  grayscale pixel to write.
REQ-011 SHALL have port busy  output  1  high from the first READ through the last WRITE.
REQ-012 SHALL have port done  output  1  one-cycle pulse when the pass completes.

Function
REQ-013 SHALL implement FSM states IDLE, READ, WRITE, DONE; IDLE->READ on start, READ->WRITE always, WRITE->READ unless last pixel, WRITE->DONE on last pixel, DONE->IDLE always.
REQ-014 SHALL in READ latch in_pix into an internal register; out_we=0.
REQ-015 SHALL in WRITE drive out_we=1 and out_pix={CH_W'0, gray, CH_W'0}, with row/col unchanged from the preceding READ.
REQ-016 SHALL advance addressing at the end of WRITE: col+1; on col wrap from 2^ADDR_W-1 to 0, row+1; raster order starting at (0,0).
REQ-017 SHALL treat (2^ADDR_W-1, 2^ADDR_W-1) as the last pixel; row and col SHALL return to 0 on leaving it.
REQ-018 SHALL take exactly 2 cycles per pixel; with start sampled at edge 0, done SHALL be high during cycle 2*4^ADDR_W+1.
REQ-019 SHALL ignore start outside IDLE; start held high continuously SHALL restart a pass from IDLE after DONE.
REQ-020 SHALL compute gray with full-width intermediates, truncating (no rounding), result CH_W bits.
REQ-021 SHALL hold out_pix at 0 whenever out_we=0.

Reset
REQ-022 SHALL on rst force state IDLE, row=0, col=0, out_we=0, out_pix=0, busy=0, done=0, latched pixel=0.
REQ-023 SHALL let rst take priority over start and over any in-progress pass; no write after the rst edge.

Configuration
REQ-024 SHALL, with GRAY_LUMA_EN defined, compute gray=(77*R+150*G+29*B)>>8.
REQ-025 SHALL, without GRAY_LUMA_EN, compute gray=(max(R,G,B)+min(R,G,B))>>1.

Structure
REQ-026 SHALL place the FSM state enum and the luma coefficients (77,150,29) in a shared package pix_pkg.
REQ-027 SHALL isolate the combinational gray computation in sub-module pix_gray_calc (parameter CH_W, input pixel, output gray).

Verification
REQ-028 SHALL test ADDR_W=2, all in_pix=0xFFFFFF, start pulse -> 16 writes, each out_pix=0x00FF00 in both modes, done at cycle 33.
REQ-029 SHALL test in_pix=0x0A1E32 everywhere -> out_pix=0x001E00 without GRAY_LUMA_EN, 0x001A00 with it.
REQ-030 SHALL test address trace -> write sequence (0,0),(0,1),(0,2),(0,3),(1,0)...(3,3), out_we high on exactly 16 cycles, alternating.
REQ-031 SHALL test start pulsed again at cycle 10 of a pass -> ignored, done still at cycle 33, single pass only.
REQ-032 SHALL test rst asserted at cycle 9 -> next cycle IDLE, row=col=0, out_we=0, busy=0; new start yields a complete pass from (0,0).

Source files
------------

// File: rtl/pix_pkg.sv
// ---------------------------------------------------------------------------
// pix_pkg
// Shared definitions for the grayscale raster scanner:
//   - state_t : FSM state encoding for pix_gray_scan
//   - LUMA_*  : 8-bit fixed-point luma weights (sum to 256) used when the
//               GRAY_LUMA_EN macro selects the weighted-luma conversion
// ---------------------------------------------------------------------------
package pix_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Weights scaled by 256, so a >>8 of the weighted sum restores channel range.
   localparam logic [7:0] LUMA_R = 8'd77;
   localparam logic [7:0] LUMA_G = 8'd150;
   localparam logic [7:0] LUMA_B = 8'd29;

endpackage : pix_pkg

// File: rtl/pix_gray_calc.sv
// ---------------------------------------------------------------------------
// pix_gray_calc
// Purely combinational RGB -> gray conversion.
//
// Configuration macro: GRAY_LUMA_EN
//   defined   : gray = (77*R + 150*G + 29*B) >> 8
//   undefined : gray = (max(R,G,B) + min(R,G,B)) >> 1
// Both forms use full-width intermediates and truncate.
//
// Parameters:
//   CH_W  - bits per colour channel
// Ports:
//   pixel - input  {R,G,B}, 3*CH_W bits, R in the MSBs
//   gray  - output CH_W-bit gray level
// ---------------------------------------------------------------------------
module pix_gray_calc
   import pix_pkg::*;
#(
   parameter int CH_W = 8
) (
   input  logic [3*CH_W-1:0] pixel,
   output logic [CH_W-1:0]   gray
);

   logic [CH_W-1:0] ch_r;
   logic [CH_W-1:0] ch_g;
   logic [CH_W-1:0] ch_b;

   assign ch_r = pixel[3*CH_W-1:2*CH_W];
   assign ch_g = pixel[2*CH_W-1:CH_W];
   assign ch_b = pixel[CH_W-1:0];

`ifdef GRAY_LUMA_EN
   // Max weighted sum is 256*(2^CH_W-1), which fits in CH_W+8 bits.
   logic [CH_W+7:0] luma_sum;

   assign luma_sum = (CH_W+8)'(ch_r) * (CH_W+8)'(LUMA_R)
                   + (CH_W+8)'(ch_g) * (CH_W+8)'(LUMA_G)
                   + (CH_W+8)'(ch_b) * (CH_W+8)'(LUMA_B);

   assign gray = CH_W'(luma_sum >> 8);
`else
   logic [CH_W-1:0] ch_max;
   logic [CH_W-1:0] ch_min;
   logic [CH_W:0]   mm_sum;

   // NOTE: every variable assigned in always_comb gets a default on entry,
   // so no path can leave it unassigned and infer a latch.
   always_comb begin
      ch_max = ch_r;
      ch_min = ch_r;
      if (ch_g > ch_max) ch_max = ch_g;
      if (ch_b > ch_max) ch_max = ch_b;
      if (ch_g < ch_min) ch_min = ch_g;
      if (ch_b < ch_min) ch_min = ch_b;
   end

   // One extra bit keeps the carry of max+min before halving.
   assign mm_sum = {1'b0, ch_max} + {1'b0, ch_min};
   assign gray   = CH_W'(mm_sum >> 1);
`endif

endmodule : pix_gray_calc

// File: rtl/pix_gray_scan.sv
// ---------------------------------------------------------------------------
// pix_gray_scan
// Walks a 2^ADDR_W x 2^ADDR_W image in raster order, reading each pixel
// (READ) and writing back its grayscale value in the green channel (WRITE),
// two cycles per pixel. A DONE pulse marks the end of the pass.
//
// Configuration macro: GRAY_LUMA_EN (selects the gray formula, see
// pix_gray_calc).
//
// Parameters:
//   ADDR_W  - row/column address width
//   CH_W    - bits per colour channel
// Ports:
//   clk     - input  clock, rising edge
//   rst     - input  synchronous active-high reset
//   start   - input  begin a pass (sampled only when idle)
//   in_pix  - input  pixel at (row,col), combinational read
//   row     - output current row address
//   col     - output current column address
//   out_we  - output write strobe for out_pix at (row,col)
//   out_pix - output {0, gray, 0}; zero whenever out_we is low
//   busy    - output high from first READ through last WRITE
//   done    - output one-cycle pulse when the pass completes
// ---------------------------------------------------------------------------
module pix_gray_scan
   import pix_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int CH_W   = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [3*CH_W-1:0]   in_pix,
   output logic [ADDR_W-1:0]   row,
   output logic [ADDR_W-1:0]   col,
   output logic                out_we,
   output logic [3*CH_W-1:0]   out_pix,
   output logic                busy,
   output logic                done
);

   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   state_t            state;
   logic [3*CH_W-1:0] pix_q;
   logic [CH_W-1:0]   gray;
   logic              col_last;
   logic              last_pix;

   assign col_last = (col == ADDR_MAX);
   assign last_pix = col_last && (row == ADDR_MAX);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      // NOTE: the pixel latch is an ordinary register, not a memory, so it is
      // cleared with the rest of the state.
      if (rst) begin
         state <= ST_IDLE;
         row   <= '0;
         col   <= '0;
         pix_q <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (start) state <= ST_READ;
            end
            ST_READ: begin
               pix_q <= in_pix;
               state <= ST_WRITE;
            end
            ST_WRITE: begin
               // Address moves only after the write; at the last pixel both
               // counters wrap to zero together.
               col <= col + 1'b1;
               if (col_last) row <= row + 1'b1;
               state <= last_pix ? ST_DONE : ST_READ;
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   pix_gray_calc #(
      .CH_W (CH_W)
   ) u_gray_calc (
      .pixel (pix_q),
      .gray  (gray)
   );

   // Outputs are pure state decodes, so reset clears them within the same
   // edge that returns the FSM to IDLE.
   assign out_we  = (state == ST_WRITE);
   assign busy    = (state == ST_READ) || (state == ST_WRITE);
   assign done    = (state == ST_DONE);
   assign out_pix = out_we ? {{CH_W{1'b0}}, gray, {CH_W{1'b0}}} : '0;

endmodule : pix_gray_scan
